// File: rtl/row_box_sum49.sv
// Horizontal 49-pixel running box sum behind the row buffer, tagged with
// row/column position, window-valid, end-of-line and end-of-frame flags.
module row_box_sum49 #(
    parameter int unsigned DATA_WIDTH   = 14,
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned WIN          = 49,
    parameter int unsigned SUM_WIDTH    = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] tap_old,
    output logic [SUM_WIDTH-1:0]  sum_out,
    output logic                  sum_valid,
    output logic [9:0]            col_out,
    output logic [8:0]            row_out,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy
);

    localparam logic [9:0]  COL_LAST = 10'(IMAGE_WIDTH - 1);
    localparam logic [9:0]  COL_FULL = 10'(WIN - 1);
    localparam logic [8:0]  ROW_LAST = 9'(IMAGE_HEIGHT - 1);
    localparam int unsigned PAD      = SUM_WIDTH + 1 - DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t               state_q, state_d;
    logic [9:0]           col_q, col_d;
    logic [8:0]           row_q, row_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [9:0]           col_out_q, col_out_d;
    logic [8:0]           row_out_q, row_out_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 eol_q, eol_d;
    logic                 eof_q, eof_d;
    logic                 busy_q, busy_d;

    logic [9:0]           pix_col;
    logic [8:0]           pix_row;
    logic                 last_col, last_row;
    logic [SUM_WIDTH:0]   acc;
    logic                 acc_unused_msb;

    assign acc_unused_msb = acc[SUM_WIDTH];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sum_d       = sum_q;
        col_out_d   = col_out_q;
        row_out_d   = row_out_q;
        sum_valid_d = 1'b0;
        eol_d       = 1'b0;
        eof_d       = 1'b0;
        busy_d      = 1'b0;

        // col_q/row_q hold the position of the next expected pixel; sof forces 0/0.
        pix_col  = sof ? '0 : col_q;
        pix_row  = sof ? '0 : row_q;
        last_col = (pix_col == COL_LAST);
        last_row = (pix_row == ROW_LAST);

        acc = {1'b0, sum_q} + {{PAD{1'b0}}, din};
        if (state_q == RUN) begin
            acc = acc - {{PAD{1'b0}}, tap_old};
        end

        if (sof || state_q != IDLE) begin
            busy_d      = 1'b1;
            col_out_d   = pix_col;
            row_out_d   = pix_row;
            sum_valid_d = (pix_col >= COL_FULL);
            eol_d       = last_col;
            eof_d       = last_col && last_row;
            // Reload at column 0 so the previous row never leaks into the sum.
            sum_d       = (pix_col == '0) ? SUM_WIDTH'(din) : acc[SUM_WIDTH-1:0];
            if (last_col) begin
                col_d   = '0;
                row_d   = last_row ? '0 : pix_row + 9'd1;
                state_d = last_row ? IDLE : FILL;
            end else begin
                col_d   = pix_col + 10'd1;
                row_d   = pix_row;
                state_d = (pix_col >= COL_FULL) ? RUN : FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            sum_q       <= '0;
            col_out_q   <= '0;
            row_out_q   <= '0;
            sum_valid_q <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sum_q       <= sum_d;
            col_out_q   <= col_out_d;
            row_out_q   <= row_out_d;
            sum_valid_q <= sum_valid_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;
    assign col_out   = col_out_q;
    assign row_out   = row_out_q;
    assign eol       = eol_q;
    assign eof       = eof_q;
    assign busy      = busy_q;

endmodule
